// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned TAG_W = 4
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req1_a;
    logic [31:0]      req0_b;
    logic [31:0]      req1_b;
    logic [3:0]       req0_ctrl;
    logic [3:0]       req1_ctrl;
    logic [TAG_W-1:0] req0_tag;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp0_ready;
    logic             rsp1_ready;
    logic [31:0]      rsp0_result;
    logic [31:0]      rsp1_result;
    logic             rsp0_flag;
    logic             rsp1_flag;
    logic [TAG_W-1:0] rsp0_tag;
    logic [TAG_W-1:0] rsp1_tag;

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_ctrl, req1_ctrl, req0_tag, req1_tag, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_flag, rsp1_flag, rsp0_tag, rsp1_tag
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_ctrl, req1_ctrl, req0_tag, req1_tag, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_flag, rsp1_flag, rsp0_tag, rsp1_tag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a registered
// response slot per requester and a branch flag derived only from the ALU result.
module alu_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [15:0]       ops_issued
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] ALU_CMD_ADD    = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_CMD_SUB    = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_CMD_AND    = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_CMD_OR     = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_CMD_XOR    = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_CMD_SLT    = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_CMD_SLL    = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_CMD_SLTU   = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_CMD_SRL    = 4'd8;
    localparam logic [CTRL_W-1:0] ALU_CMD_SRA    = 4'd9;
    localparam logic [CTRL_W-1:0] ALU_CMD_COPY_A = 4'd10;
    localparam logic [CTRL_W-1:0] ALU_CMD_COPY_B = 4'd11;

    logic [1:0]              slot_free;
    logic [1:0]              elig;
    logic [1:0]              grant;
    logic [DATA_W-1:0]       alu_a;
    logic [DATA_W-1:0]       alu_b;
    logic [CTRL_W-1:0]       alu_ctrl;
    logic [DATA_W-1:0]       alu_out;
    logic                    alu_flag;

    logic                    prio_q, prio_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [1:0][DATA_W-1:0]  result_q, result_d;
    logic [1:0]              flag_q, flag_d;
    logic [1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]        ops_q, ops_d;

    // Eligibility and grant; a draining slot counts as free, nothing is granted in reset.
    always_comb begin
        slot_free = ~rsp_valid_q | {bus.rsp1_ready, bus.rsp0_ready};
        elig      = {bus.req1_valid, bus.req0_valid} & slot_free & {2{rst_n}};
        grant     = 2'b00;
        grant[0]  = elig[0] && (!elig[1] || !prio_q);
        grant[1]  = elig[1] && (!elig[0] ||  prio_q);
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // Operand mux: requester 0 drives the ALU unless requester 1 is granted.
    always_comb begin
        alu_a    = bus.req0_a;
        alu_b    = bus.req0_b;
        alu_ctrl = bus.req0_ctrl;
        if (grant[1]) begin
            alu_a    = bus.req1_a;
            alu_b    = bus.req1_b;
            alu_ctrl = bus.req1_ctrl;
        end
    end

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            ALU_CMD_ADD:    alu_out = alu_a + alu_b;
            ALU_CMD_SUB:    alu_out = alu_a - alu_b;
            ALU_CMD_AND:    alu_out = alu_a & alu_b;
            ALU_CMD_OR:     alu_out = alu_a | alu_b;
            ALU_CMD_XOR:    alu_out = alu_a ^ alu_b;
            ALU_CMD_SLT:    alu_out = DATA_W'($signed(alu_a) < $signed(alu_b));
            ALU_CMD_SLL:    alu_out = alu_a << alu_b[SHAMT_W-1:0];
            ALU_CMD_SLTU:   alu_out = DATA_W'(alu_a < alu_b);
            ALU_CMD_SRL:    alu_out = alu_a >> alu_b[SHAMT_W-1:0];
            ALU_CMD_SRA:    alu_out = $unsigned($signed(alu_a) >>> alu_b[SHAMT_W-1:0]);
            ALU_CMD_COPY_A: alu_out = alu_a;
            ALU_CMD_COPY_B: alu_out = alu_b;
            default:        alu_out = '0;
        endcase
    end

    // Flag comes from the result only; the raw ALU flag is undefined for most commands.
    always_comb begin
        alu_flag = 1'b0;
        case (alu_ctrl)
            ALU_CMD_SUB:  alu_flag = (alu_out == '0);
            ALU_CMD_SLT,
            ALU_CMD_SLTU: alu_flag = alu_out[0];
            default:      alu_flag = 1'b0;
        endcase
    end

    always_comb begin
        prio_d      = prio_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        flag_d      = flag_q;
        tag_d       = tag_q;
        ops_d       = ops_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                rsp_valid_d[i] = 1'b1;
                result_d[i]    = alu_out;
                flag_d[i]      = alu_flag;
                tag_d[i]       = (i == 0) ? bus.req0_tag : bus.req1_tag;
            end else if (rsp_valid_q[i] && slot_free[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
        if (grant[0]) prio_d = 1'b1;
        if (grant[1]) prio_d = 1'b0;
        if (|grant)   ops_d  = ops_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= '0;
            result_q    <= '0;
            flag_q      <= '0;
            tag_q       <= '0;
            ops_q       <= '0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            tag_q       <= tag_d;
            ops_q       <= ops_d;
        end
    end

    assign bus.rsp0_valid  = rsp_valid_q[0];
    assign bus.rsp1_valid  = rsp_valid_q[1];
    assign bus.rsp0_result = result_q[0];
    assign bus.rsp1_result = result_q[1];
    assign bus.rsp0_flag   = flag_q[0];
    assign bus.rsp1_flag   = flag_q[1];
    assign bus.rsp0_tag    = tag_q[0];
    assign bus.rsp1_tag    = tag_q[1];
    assign ops_issued      = ops_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU instance between two requesters, such as the integer execute path and the branch/address-compare path. Each cycle it grants at most one valid request, using round-robin priority, and drives the operands into the ALU. It captures the result in a per-requester response register held until that requester accepts it. It normalises `branch_flag` so that it is never a stale value.

## Interface
- `TAG_W`, default 4: width of the opaque tag carried from request to response.
- `clk` in 1: the only clock; rising-edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `req0_valid`, `req1_valid` in 1: request present.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle (the grant).
- `req0_a`, `req1_a` in 32: ALU `src_a`.
- `req0_b`, `req1_b` in 32: ALU `src_b`.
- `req0_ctrl`, `req1_ctrl` in 4: ALU command, `ALU_CMD_*` encoding from constants.v.
- `req0_tag`, `req1_tag` in `TAG_W`: returned unchanged with the response.
- `rsp0_valid`, `rsp1_valid` out 1: response register full.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes the response.
- `rsp0_result`, `rsp1_result` out 32: ALU `out`.
- `rsp0_flag`, `rsp1_flag` out 1: normalised branch flag.
- `rsp0_tag`, `rsp1_tag` out `TAG_W`: tag of the request that produced the response.
- `ops_issued` out 16: count of granted operations; wraps at 16'hFFFF → 0.

## Operation
- **Slot i free:** `!rsp_i_valid || rsp_i_ready`. A full slot that drains this cycle counts as free.
- **Eligible i:** `req_i_valid && slot_i_free`.
- **Arbitration:**
  - One eligible requester is granted.
  - Both eligible: the requester named by priority pointer `prio` (1 bit) is granted.
  - `req_i_ready = grant_i`.
  - At most one `req_i_ready` is high per cycle.
  - `req_i_ready` may depend combinationally on `req_(1-i)_valid` and `rsp_i_ready`.
- **Pointer:** after a grant to i, `prio` ← 1-i. With no grant, `prio` holds.
- **ALU mux:** the ALU sees the granted requester's a/b/ctrl. With no grant it sees requester 0's inputs, and the result is discarded.
- **Flag normalisation:** computed from ALU `out` only, never from ALU `branch_flag`, because that output is not driven for all commands.
  - `ALU_CMD_SUB`: `flag = (out == 0)`.
  - `ALU_CMD_SLT` and `ALU_CMD_SLTU`: `flag = out[0]`.
  - All other commands: `flag = 0`.
- **Capture:** on the grant edge, slot i loads result, flag and tag, and `rsp_i_valid` ← 1.
- **Drain:** if `rsp_i_valid && rsp_i_ready` with no new grant to i, `rsp_i_valid` ← 0.
- **Drain and grant together:** the slot reloads and `rsp_i_valid` stays 1.
- **Response stability:** result, flag and tag are stable while `rsp_i_valid && !rsp_i_ready`.
- **Requester obligation:** `req_i_*` must be held stable while `req_i_valid && !req_i_ready`. The arbiter never drops a request whose `ready` was low.
- **Counter:** `ops_issued` increments by 1 on every grant.

## Timing
- **Reset values (async assert, sync deassert by the surrounding reset logic):**
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp*_result` = 0, `rsp*_flag` = 0, `rsp*_tag` = 0.
  - `prio` = 0.
  - `ops_issued` = 0.
- **During reset:** `req*_ready` = 0 while `rst_n` is low.
- **Latency:** grant in cycle N gives `rsp_i_valid` = 1 in cycle N+1. The result is registered; there is no combinational path from `req_*` to `rsp_*`.
- **Throughput:**
  - 1 op/cycle aggregate.
  - A single requester with `rsp_ready` tied high is granted every cycle while the other is idle.
- **Fairness:** with both requesting continuously and both slots draining, grants alternate 0,1,0,1… starting from the `prio` value.
- **Blocked requester:** a requester whose slot is full and not draining loses eligibility. The other requester may then win back-to-back, and the pointer still updates.
- **Reset mid-operation:** pending responses and tags are discarded. After `rst_n` rises, the first simultaneous request goes to requester 0.
- **Counter wrap:** at 16'hFFFF, the next grant gives 0. No other side effect.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-traffic → all `rsp_valid` = 0, `ops_issued` = 0 immediately (asynchronous). After release, with both requesting, requester 0 is granted first.
- **Single op:**
  - Stimulus: `req0` ADD a=7, b=5, tag=3, `rsp0_ready` = 1.
  - Response: `req0_ready` = 1 in cycle N; cycle N+1 gives `rsp0_valid` = 1, result = 12, flag = 0, tag = 3; `ops_issued` = 1.
- **Flag normalisation, back-to-back on `req1`:**
  - SUB 9,9 → result 0, flag 1.
  - SLT 0xFFFFFFFF,1 → result 1, flag 1.
  - SLTU 0xFFFFFFFF,1 → result 0, flag 0.
  - XOR issued after the SLT → flag 0, not the stale 1.
- **Round-robin:** both valid every cycle for 6 cycles, both `rsp_ready` = 1 → grant sequence 0,1,0,1,0,1; `ops_issued` = 6.
- **Backpressure:**
  - `rsp0_ready` = 0 with slot 0 full and `req0` valid → `req0_ready` stays 0, `rsp0` payload unchanged, and `req1` wins every cycle.
  - Raise `rsp0_ready` → `req0` is granted in that same cycle (drain plus reload), and `rsp0_valid` stays 1 with the new result.
- **Counter wrap:** preload by issuing 65535 ops, then 1 more op → `ops_issued` reads 0. Arbitration is unaffected.
